// File: rtl/yolo_stream_pkg.sv
// Shared types and sizing helpers for the yolo stream buffers.
package yolo_stream_pkg;

  // Frame tracker state: waiting for the first beat of a frame, or inside one
  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } frame_state_e;

  // Stored entry layout is {user, last, keep, data}
  function automatic int entry_width(input int tbits);
    return tbits + (tbits / 8) + 2;
  endfunction

  // Level counter must represent 0..DEPTH inclusive
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/yolo_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with an occupancy level output.
// The head entry is visible on dout whenever empty_n is high; a write only
// becomes visible after the clock edge that stores it.
module yolo_sync_fifo
  import yolo_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int LVL_W = level_width(DEPTH),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty_n
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Guard both ports so overflow and underflow can never corrupt pointers
  always_comb begin
    push_ok_s = push & (level_r != LVL_W'(DEPTH));
    pop_ok_s  = pop & (level_r != {LVL_W{1'b0}});
  end

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
    end
  end

  // Occupancy count; a simultaneous push and pop leaves it unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_r <= {LVL_W{1'b0}};
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  assign dout    = mem_r[rd_ptr_r];
  assign level   = level_r;
  assign full    = (level_r == LVL_W'(DEPTH));
  assign empty_n = (level_r != {LVL_W{1'b0}});

endmodule

// File: rtl/yolo_axis_in_buf.sv
// AXI4-Stream slave input buffer for yolo_core. Beats are stored in a FWFT
// FIFO and presented on the isif handshake. A frame tracker counts beats
// against cfg_frame_len, forces TLAST when the expected length is reached,
// and records sticky short/long frame errors plus a wrapping frame count.
module yolo_axis_in_buf
  import yolo_stream_pkg::*;
#(
  parameter int TBITS    = 64,
  parameter int TBYTE    = TBITS / 8,
  parameter int DEPTH    = 16,
  parameter int AFULL_TH = DEPTH - 2,
  parameter int LEN_W    = 16,
  localparam int LVL_W   = level_width(DEPTH),
  localparam int ENT_W   = entry_width(TBITS)
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             S_AXIS_MM2S_TVALID,
  output logic             S_AXIS_MM2S_TREADY,
  input  logic [TBITS-1:0] S_AXIS_MM2S_TDATA,
  input  logic [TBYTE-1:0] S_AXIS_MM2S_TKEEP,
  input  logic             S_AXIS_MM2S_TLAST,
  input  logic             S_AXIS_MM2S_TUSER,
  output logic [TBITS-1:0] isif_data_dout,
  output logic [TBYTE-1:0] isif_strb_dout,
  output logic             isif_last_dout,
  output logic             isif_user_dout,
  output logic             isif_empty_n,
  input  logic             isif_read,
  output logic [LVL_W-1:0] isif_level,
  output logic             isif_afull,
  input  logic [LEN_W-1:0] cfg_frame_len,
  input  logic             err_clr,
  output logic             err_short,
  output logic             err_long,
  output logic [LEN_W-1:0] frame_cnt
);

  frame_state_e     state_r;
  logic [LEN_W-1:0] beat_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] frame_cnt_r;
  logic             err_short_r;
  logic             err_long_r;
  logic             ready_en_r;

  logic             fifo_full_s;
  logic             push_s;
  logic [LEN_W-1:0] beat_now_s;
  logic [LEN_W-1:0] len_now_s;
  logic             hit_len_s;
  logic             terminal_s;
  logic             short_set_s;
  logic             long_set_s;
  logic [ENT_W-1:0] entry_in_s;
  logic [ENT_W-1:0] entry_out_s;

  // Hold TREADY low while in reset and for the first edge after release
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ready_en_r <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
    end
  end

  assign S_AXIS_MM2S_TREADY = ready_en_r & ~fifo_full_s;
  assign push_s             = S_AXIS_MM2S_TVALID & S_AXIS_MM2S_TREADY;

  // Classify the incoming beat; the length is latched on the first beat only
  always_comb begin
    beat_now_s  = beat_r + LEN_W'(1);
    len_now_s   = len_r;
    if (state_r == IDLE) begin
      beat_now_s = LEN_W'(1);
      len_now_s  = cfg_frame_len;
    end else begin
      beat_now_s = beat_r + LEN_W'(1);
      len_now_s  = len_r;
    end
    hit_len_s   = (len_now_s != {LEN_W{1'b0}}) && (beat_now_s == len_now_s);
    terminal_s  = S_AXIS_MM2S_TLAST | hit_len_s;
    short_set_s = push_s & S_AXIS_MM2S_TLAST & (len_now_s != {LEN_W{1'b0}})
                  & (beat_now_s < len_now_s);
    long_set_s  = push_s & hit_len_s & ~S_AXIS_MM2S_TLAST;
  end

  // Frame tracker: beat counting, latched length and frame counter
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r     <= IDLE;
      beat_r      <= {LEN_W{1'b0}};
      len_r       <= {LEN_W{1'b0}};
      frame_cnt_r <= {LEN_W{1'b0}};
    end else if (push_s) begin
      len_r <= len_now_s;
      if (terminal_s) begin
        state_r     <= IDLE;
        beat_r      <= {LEN_W{1'b0}};
        frame_cnt_r <= frame_cnt_r + LEN_W'(1);
      end else begin
        state_r     <= IN_FRAME;
        beat_r      <= beat_now_s;
      end
    end
  end

  // Sticky error flags; a new error wins over a clear in the same cycle
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_short_r <= 1'b0;
      err_long_r  <= 1'b0;
    end else begin
      if (short_set_s) begin
        err_short_r <= 1'b1;
      end else if (err_clr) begin
        err_short_r <= 1'b0;
      end
      if (long_set_s) begin
        err_long_r <= 1'b1;
      end else if (err_clr) begin
        err_long_r <= 1'b0;
      end
    end
  end

  assign entry_in_s = {S_AXIS_MM2S_TUSER, terminal_s, S_AXIS_MM2S_TKEEP, S_AXIS_MM2S_TDATA};

  yolo_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (aclk),
    .rst_n   (aresetn),
    .push    (push_s),
    .din     (entry_in_s),
    .pop     (isif_read),
    .dout    (entry_out_s),
    .level   (isif_level),
    .full    (fifo_full_s),
    .empty_n (isif_empty_n)
  );

  assign isif_data_dout = entry_out_s[TBITS-1:0];
  assign isif_strb_dout = entry_out_s[TBITS +: TBYTE];
  assign isif_last_dout = entry_out_s[TBITS+TBYTE];
  assign isif_user_dout = entry_out_s[TBITS+TBYTE+1];
  assign isif_afull     = (isif_level >= LVL_W'(AFULL_TH));
  assign err_short      = err_short_r;
  assign err_long       = err_long_r;
  assign frame_cnt      = frame_cnt_r;

endmodule

// File: tb/tb_yolo_axis_in_buf.sv
// Directed self-checking bench for yolo_axis_in_buf (DEPTH=16, TBITS=64).
module tb_yolo_axis_in_buf;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic [63:0] tdata = '0;
  logic [7:0]  tkeep = '0;
  logic        tlast = 1'b0;
  logic        tuser = 1'b0;
  logic [63:0] isif_data_dout;
  logic [7:0]  isif_strb_dout;
  logic        isif_last_dout;
  logic        isif_user_dout;
  logic        isif_empty_n;
  logic        isif_read = 1'b0;
  logic [4:0]  isif_level;
  logic        isif_afull;
  logic [15:0] cfg_frame_len = '0;
  logic        err_clr = 1'b0;
  logic        err_short;
  logic        err_long;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int exp_frames = 0;

  always #5 aclk = ~aclk;

  yolo_axis_in_buf dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .S_AXIS_MM2S_TVALID (tvalid),
    .S_AXIS_MM2S_TREADY (tready),
    .S_AXIS_MM2S_TDATA  (tdata),
    .S_AXIS_MM2S_TKEEP  (tkeep),
    .S_AXIS_MM2S_TLAST  (tlast),
    .S_AXIS_MM2S_TUSER  (tuser),
    .isif_data_dout     (isif_data_dout),
    .isif_strb_dout     (isif_strb_dout),
    .isif_last_dout     (isif_last_dout),
    .isif_user_dout     (isif_user_dout),
    .isif_empty_n       (isif_empty_n),
    .isif_read          (isif_read),
    .isif_level         (isif_level),
    .isif_afull         (isif_afull),
    .cfg_frame_len      (cfg_frame_len),
    .err_clr            (err_clr),
    .err_short          (err_short),
    .err_long           (err_long),
    .frame_cnt          (frame_cnt)
  );

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic push_beat(input logic [63:0] d, input logic last);
    tvalid = 1'b1; tdata = d; tkeep = 8'hFF; tlast = last; tuser = 1'b0;
    step();
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %0b want 0", tready); end
    checks++; if (isif_empty_n !== 1'b0) begin errors++; $display("FAIL reset_empty_n got %0b want 0", isif_empty_n); end
    checks++; if (isif_level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", isif_level); end
    checks++; if (isif_afull !== 1'b0) begin errors++; $display("FAIL reset_afull got %0b want 0", isif_afull); end
    checks++; if ({err_short, err_long} !== 2'b00) begin errors++; $display("FAIL reset_err got %b want 00", {err_short, err_long}); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
    step();
    checks++; if (tready !== 1'b0) begin errors++; $display("FAIL reset_tready_held got %0b want 0", tready); end
    aresetn = 1'b1;
    step();
    checks++; if (tready !== 1'b1) begin errors++; $display("FAIL reset_tready_after got %0b want 1", tready); end
  endtask

  task automatic test_fill();
    int pushed = 0;
    logic exp_rdy;
    cfg_frame_len = 16'd0;
    for (int i = 0; i < 20; i++) begin
      exp_rdy = (pushed != 16);
      checks++; if (tready !== exp_rdy) begin errors++; $display("FAIL fill_tready beat %0d got %0b want %0b", i, tready, exp_rdy); end
      tvalid = 1'b1; tdata = 64'h1000 + 64'(pushed); tkeep = 8'hFF; tlast = 1'b0; tuser = pushed[0];
      step();
      if (exp_rdy) pushed++;
      checks++; if (isif_level !== 5'(pushed)) begin errors++; $display("FAIL fill_level beat %0d got %0d want %0d", i, isif_level, pushed); end
      checks++; if (isif_afull !== (pushed >= 14)) begin errors++; $display("FAIL fill_afull beat %0d got %0b want %0b", i, isif_afull, pushed >= 14); end
    end
    tvalid = 1'b0;
    checks++; if (isif_data_dout !== 64'h1000) begin errors++; $display("FAIL fill_head got %h want 1000", isif_data_dout); end
    isif_read = 1'b1;
    step();
    isif_read = 1'b0;
    checks++; if (isif_level !== 5'd15) begin errors++; $display("FAIL fill_level_pop got %0d want 15", isif_level); end
    checks++; if (tready !== 1'b1) begin errors++; $display("FAIL fill_tready_pop got %0b want 1", tready); end
    for (int k = 1; k < 16; k++) begin
      checks++; if (isif_data_dout !== 64'h1000 + 64'(k) || isif_user_dout !== k[0] || isif_last_dout !== 1'b0) begin
        errors++; $display("FAIL fill_order %0d got %h/%0b/%0b want %h/%0b/0", k, isif_data_dout, isif_user_dout, isif_last_dout, 64'h1000 + 64'(k), k[0]);
      end
      isif_read = 1'b1; step(); isif_read = 1'b0;
    end
    checks++; if (isif_empty_n !== 1'b0) begin errors++; $display("FAIL fill_drained got %0b want 0", isif_empty_n); end
    // read while empty must not underflow
    isif_read = 1'b1; step(); isif_read = 1'b0;
    checks++; if (isif_level !== 5'd0) begin errors++; $display("FAIL underflow_level got %0d want 0", isif_level); end
  endtask

  task automatic test_frame_ok();
    cfg_frame_len = 16'd4;
    push_beat(64'hA1, 1'b0);
    cfg_frame_len = 16'd2; // must be ignored until the frame ends
    push_beat(64'hA2, 1'b0);
    push_beat(64'hA3, 1'b0);
    push_beat(64'hA4, 1'b1);
    cfg_frame_len = 16'd4;
    exp_frames = 1;
    checks++; if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL ok_frame_cnt got %0d want %0d", frame_cnt, exp_frames); end
    checks++; if ({err_short, err_long} !== 2'b00) begin errors++; $display("FAIL ok_err got %b want 00", {err_short, err_long}); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (isif_data_dout !== 64'hA1 + 64'(k) || isif_last_dout !== (k == 3)) begin
        errors++; $display("FAIL ok_pop %0d got %h/%0b want %h/%0b", k, isif_data_dout, isif_last_dout, 64'hA1 + 64'(k), k == 3);
      end
      isif_read = 1'b1; step(); isif_read = 1'b0;
    end
  endtask

  task automatic test_short();
    logic [5:0] exp_last = 6'b100010; // bit k = last of pop k
    push_beat(64'hB1, 1'b0);
    push_beat(64'hB2, 1'b1);
    exp_frames++;
    checks++; if (err_short !== 1'b1 || err_long !== 1'b0) begin errors++; $display("FAIL short_err got %b want 10", {err_short, err_long}); end
    checks++; if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL short_frame_cnt got %0d want %0d", frame_cnt, exp_frames); end
    for (int k = 0; k < 4; k++) push_beat(64'hC1 + 64'(k), k == 3);
    exp_frames++;
    checks++; if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL short_next_cnt got %0d want %0d", frame_cnt, exp_frames); end
    checks++; if (err_long !== 1'b0 || err_short !== 1'b1) begin errors++; $display("FAIL short_sticky got %b want 10", {err_short, err_long}); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (isif_last_dout !== exp_last[k]) begin errors++; $display("FAIL short_last pop %0d got %0b want %0b", k, isif_last_dout, exp_last[k]); end
      isif_read = 1'b1; step(); isif_read = 1'b0;
    end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    checks++; if (err_short !== 1'b0) begin errors++; $display("FAIL short_clr got %0b want 0", err_short); end
  endtask

  task automatic test_long();
    logic [5:0] exp_last = 6'b101000;
    for (int k = 0; k < 6; k++) push_beat(64'hD1 + 64'(k), k == 5);
    exp_frames += 2;
    checks++; if ({err_short, err_long} !== 2'b11) begin errors++; $display("FAIL long_err got %b want 11", {err_short, err_long}); end
    checks++; if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL long_frame_cnt got %0d want %0d", frame_cnt, exp_frames); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (isif_last_dout !== exp_last[k] || isif_data_dout !== 64'hD1 + 64'(k)) begin
        errors++; $display("FAIL long_pop %0d got %h/%0b want %h/%0b", k, isif_data_dout, isif_last_dout, 64'hD1 + 64'(k), exp_last[k]);
      end
      isif_read = 1'b1; step(); isif_read = 1'b0;
    end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    checks++; if ({err_short, err_long} !== 2'b00) begin errors++; $display("FAIL long_clr got %b want 00", {err_short, err_long}); end
    // clear in the same cycle as a new short error: set wins
    push_beat(64'hE1, 1'b0);
    err_clr = 1'b1;
    push_beat(64'hE2, 1'b1);
    err_clr = 1'b0;
    exp_frames++;
    checks++; if (err_short !== 1'b1) begin errors++; $display("FAIL set_wins got %0b want 1", err_short); end
    isif_read = 1'b1; step(); step(); isif_read = 1'b0;
    err_clr = 1'b1; step(); err_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [63:0] sd [1001];
    logic [7:0]  sk [1001];
    logic        sl [1001];
    logic        su [1001];
    int bad = 0;
    cfg_frame_len = 16'd0;
    for (int k = 0; k < 1001; k++) begin
      sd[k] = {$urandom, $urandom};
      sk[k] = 8'($urandom_range(0, 255));
      sl[k] = ($urandom_range(0, 7) == 0);
      su[k] = 1'($urandom_range(0, 1));
    end
    tvalid = 1'b1; tdata = sd[0]; tkeep = sk[0]; tlast = sl[0]; tuser = su[0];
    step();
    if (sl[0]) exp_frames++;
    for (int k = 1; k <= 1000; k++) begin
      checks++;
      if (isif_level !== 5'd1 || isif_data_dout !== sd[k-1] || isif_strb_dout !== sk[k-1]
          || isif_last_dout !== sl[k-1] || isif_user_dout !== su[k-1]) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL stream beat %0d got lvl %0d %h/%h/%0b/%0b want lvl 1 %h/%h/%0b/%0b",
          k - 1, isif_level, isif_data_dout, isif_strb_dout, isif_last_dout, isif_user_dout,
          sd[k-1], sk[k-1], sl[k-1], su[k-1]);
      end
      tvalid = (k < 1000); tdata = sd[k]; tkeep = sk[k]; tlast = sl[k]; tuser = su[k];
      isif_read = 1'b1;
      step();
      if (k < 1000 && sl[k]) exp_frames++;
    end
    tvalid = 1'b0; isif_read = 1'b0; tlast = 1'b0;
    checks++; if (isif_level !== 5'd0) begin errors++; $display("FAIL stream_end_level got %0d want 0", isif_level); end
    checks++; if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL stream_frame_cnt got %0d want %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_reset_mid();
    cfg_frame_len = 16'd8;
    for (int k = 0; k < 7; k++) push_beat(64'hF0 + 64'(k), 1'b0);
    checks++; if (isif_level !== 5'd7) begin errors++; $display("FAIL mid_level got %0d want 7", isif_level); end
    #2 aresetn = 1'b0;
    #1;
    checks++; if (isif_empty_n !== 1'b0 || isif_level !== 5'd0) begin errors++; $display("FAIL mid_reset_fifo got %0b/%0d want 0/0", isif_empty_n, isif_level); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL mid_reset_cnt got %0d want 0", frame_cnt); end
    checks++; if (tready !== 1'b0) begin errors++; $display("FAIL mid_reset_tready got %0b want 0", tready); end
    step();
    aresetn = 1'b1;
    cfg_frame_len = 16'd4;
    step();
    for (int k = 0; k < 4; k++) push_beat(64'h51 + 64'(k), k == 3);
    checks++; if ({err_short, err_long} !== 2'b00) begin errors++; $display("FAIL mid_new_err got %b want 00", {err_short, err_long}); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL mid_new_cnt got %0d want 1", frame_cnt); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (isif_data_dout !== 64'h51 + 64'(k) || isif_last_dout !== (k == 3)) begin
        errors++; $display("FAIL mid_pop %0d got %h/%0b want %h/%0b", k, isif_data_dout, isif_last_dout, 64'h51 + 64'(k), k == 3);
      end
      isif_read = 1'b1; step(); isif_read = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_frame_ok();
    test_short();
    test_long();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/yolo_axis_in_buf.md
Name: yolo_axis_in_buf

Overview:
Parametrised AXI4-Stream slave input buffer that replaces the fixed input stream interface in front of yolo_core.
- Accepts MM2S beats into a configurable-depth first-word-fall-through FIFO.
- Presents them on the isif_* handshake.
- Adds frame-length checking with TLAST repair, a fill-level/almost-full indication, and frame/error counters for debug.

Parameters:
TBITS, 64, stream data width in bits (multiple of 8)
TBYTE, TBITS/8, TKEEP width
DEPTH, 16, FIFO entries (power of 2, >=2)
AFULL_TH, DEPTH-2, level at or above which isif_afull asserts
LEN_W, 16, width of frame-length config and counters

Ports:
aclk  in  1  clock, all logic single domain
aresetn  in  1  asynchronous active-low reset
S_AXIS_MM2S_TVALID  in  1  upstream beat valid
S_AXIS_MM2S_TREADY  out  1  buffer can accept
S_AXIS_MM2S_TDATA  in  TBITS  beat data
S_AXIS_MM2S_TKEEP  in  TBYTE  byte enables
S_AXIS_MM2S_TLAST  in  1  end of frame
S_AXIS_MM2S_TUSER  in  1  sideband, stored as-is
isif_data_dout  out  TBITS  head-entry data
isif_strb_dout  out  TBYTE  head-entry keep
isif_last_dout  out  1  head-entry last (possibly repaired)
isif_user_dout  out  1  head-entry user
isif_empty_n  out  1  head entry valid
isif_read  in  1  consumer pops head
isif_level  out  log2(DEPTH)+1  entries held
isif_afull  out  1  level >= AFULL_TH
cfg_frame_len  in  LEN_W  expected beats per frame; 0 disables checking
err_clr  in  1  clears sticky error flags
err_short  out  1  sticky: TLAST before cfg length
err_long  out  1  sticky: length reached without TLAST
frame_cnt  out  LEN_W  frames stored, wraps

Behaviour:
- Reset (aresetn low, async): FIFO empty, TREADY=0 during reset then 1, empty_n=0, level=0, afull=0, err flags=0, frame_cnt=0, beat counter=0, FSM=IDLE. isif_* data outputs are don't-care while empty_n=0.
- Reset mid-frame: all content and partial frame are discarded; no flush beat is emitted.
- Write: TREADY = (level != DEPTH), derived from registered level only. Push on TVALID&TREADY.
- Read: pop on isif_read&isif_empty_n. isif_read while empty is ignored, with no underflow.
- FWFT latency: a beat accepted at edge N shows empty_n=1 with its data after edge N. No combinational bypass from S_AXIS to isif.
- Simultaneous push and pop: level unchanged. At full, TREADY=0, so no push occurs even if a pop happens in the same cycle; TREADY returns one cycle after the pop.
- Entry format: {user, last_stored, keep, data}. Pointers wrap modulo DEPTH.
- Frame FSM, IDLE:
  - First accepted beat latches len_q=cfg_frame_len, sets beat=1 and moves to IN_FRAME.
  - If that beat is also terminal, stay in IDLE.
- Frame FSM, IN_FRAME: each accepted beat increments beat.
- Terminal beat is one of:
  - TLAST=1, or
  - len_q!=0 and beat==len_q (the counted value including this beat).
- On a terminal beat:
  - last_stored=1.
  - frame_cnt++ (wrapping).
  - FSM returns to IDLE with beat=0.
- err_short: set when TLAST=1 and len_q!=0 and beat<len_q.
- err_long: set when len_q!=0, beat==len_q and TLAST=0. The stored last is forced to 1, so the following input beats start a new frame.
- err_clr versus new error in the same cycle: set wins.
- With len_q=0 (check disabled): last_stored=TLAST, and errors never set.
- cfg_frame_len changes mid-frame have no effect until the next IDLE.
- Width: beat counter is LEN_W bits; saturation is not needed because the compare triggers before wrap when len_q!=0. With len_q=0 the counter wraps silently.

Decomposition:
- Package yolo_stream_pkg holds:
  - localparam functions for entry width (TBITS+TBYTE+2) and clog2 level width;
  - the frame FSM state enum {IDLE, IN_FRAME}.
- Sub-module yolo_sync_fifo (width/depth parametrised, FWFT, level output) is natural and will be reused on the output side.
- Frame tracking and error logic stays in yolo_axis_in_buf.

Test Plan:
1. DEPTH=16, cfg=0: 20 back-to-back beats, isif_read=0 -> TREADY drops after beat 16, level=16, afull=1 from level 14. Then read 1 -> TREADY=1 the next cycle, data order preserved.
2. cfg=4: frame of 4 beats with TLAST on beat 4 -> last_dout=1 on 4th pop only, frame_cnt=1, no errors.
3. cfg=4: TLAST on beat 2 -> err_short=1, frame_cnt=1. A following 4-beat frame is accepted cleanly, frame_cnt=2.
4. cfg=4: 6 beats with TLAST on 6 -> beat 4 stored with last=1, err_long=1, beat 6 also terminal (err_short set since beat=2<4), frame_cnt=2. Pulse err_clr -> both flags 0.
5. Continuous write and read every cycle with random TKEEP/TUSER -> level constant at 1, every beat matches input, no beat lost or duplicated over 1000 beats.
6. Assert aresetn low with level=7 mid-frame -> empty_n=0, level=0, frame_cnt=0 immediately. After release, a new frame is counted from beat 1.
